// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// Requests are arbitrated round-robin, each accepted op drives the ALU for a
// single cycle, and the result lands in a one-deep response buffer per port.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_type,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_type,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_err,
  output logic [3:0]        alu_type,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  input  logic [DATA_W-1:0] alu_result,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
);

  // Op code presented to the ALU when nobody is granted.
  localparam logic [3:0] OP_NDEF = 4'd8;

  // Port that won the most recent handshake; the other port wins the next tie.
  logic last_grant;
  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;

  // A port is eligible when it requests and its buffer is empty or being drained;
  // ties go to the port that did not win last time, and reset blocks all grants.
  always_comb begin
    elig0  = req0_valid & (~rsp0_valid | rsp0_ready);
    elig1  = req1_valid & (~rsp1_valid | rsp1_ready);
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (elig0 && elig1) begin
        grant0 = last_grant;
        grant1 = ~last_grant;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Steer the granted port's operation onto the shared ALU, or park it on NDEF.
  always_comb begin
    alu_type = OP_NDEF;
    alu_src1 = '0;
    alu_src2 = '0;
    if (grant0) begin
      alu_type = req0_type;
      alu_src1 = req0_src1;
      alu_src2 = req0_src2;
    end else if (grant1) begin
      alu_type = req1_type;
      alu_src1 = req1_src1;
      alu_src2 = req1_src2;
    end
  end

  // Remember the winner of each handshake for round-robin tie breaking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant0) begin
      last_grant <= 1'b0;
    end else if (grant1) begin
      last_grant <= 1'b1;
    end
  end

  // Port 0 response buffer: a new load beats a simultaneous pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_err   <= 1'b0;
    end else if (grant0) begin
      rsp0_valid <= 1'b1;
      rsp0_data  <= alu_result;
      rsp0_err   <= req0_type[3];
    end else if (rsp0_valid && rsp0_ready) begin
      rsp0_valid <= 1'b0;
    end
  end

  // Port 1 response buffer: a new load beats a simultaneous pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_err   <= 1'b0;
    end else if (grant1) begin
      rsp1_valid <= 1'b1;
      rsp1_data  <= alu_result;
      rsp1_err   <= req1_type[3];
    end else if (rsp1_valid && rsp1_ready) begin
      rsp1_valid <= 1'b0;
    end
  end

  // Per-port handshake counters, free-running and wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (grant0) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (grant1) gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios followed by a randomized run, all checked
// against a transaction-level model of the arbiter kept in this bench. A second
// instance with 2-bit counters exercises counter wrap-around.
module tb_alu_arbiter;

  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Stimulus, indexed by port.
  bit          v[2];
  logic [3:0]  t[2];
  logic [31:0] a[2];
  logic [31:0] b[2];
  bit          rr[2];

  // Main instance outputs.
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_data, rsp1_data, alu_src1, alu_src2, alu_result;
  logic [3:0]  alu_type;
  logic [15:0] gnt_cnt0, gnt_cnt1;

  // Narrow-counter instance outputs.
  logic        w_req0_ready, w_req1_ready, w_rsp0_valid, w_rsp1_valid, w_rsp0_err, w_rsp1_err;
  logic [31:0] w_rsp0_data, w_rsp1_data, w_alu_src1, w_alu_src2, w_alu_result;
  logic [3:0]  w_alu_type;
  logic [1:0]  w_gnt_cnt0, w_gnt_cnt1;

  int total = 0;
  int bad   = 0;

  // Transaction-level model state.
  int          m_last;
  bit          m_val[2];
  logic [31:0] m_dat[2];
  bit          m_err[2];
  int          m_cnt[2];

  // Observations from the most recent cycle, for directed checks.
  int          last_g;
  logic        obs_r0, obs_r1;
  logic [3:0]  obs_type;

  // The external ALU; undefined codes return an operand mix so masking would show.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x << y[4:0];
      4'd3: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd4: return x ^ y;
      4'd5: return x >> y[4:0];
      4'd6: return x | y;
      4'd7: return x & y;
      default: return {x[15:0], y[15:0]};
    endcase
  endfunction

  assign alu_result   = alu_fn(alu_type, alu_src1, alu_src2);
  assign w_alu_result = alu_fn(w_alu_type, w_alu_src1, w_alu_src2);

  alu_arbiter #(.DATA_W(DATA_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_ready(req0_ready), .req0_type(t[0]), .req0_src1(a[0]), .req0_src2(b[0]),
    .req1_valid(v[1]), .req1_ready(req1_ready), .req1_type(t[1]), .req1_src1(a[1]), .req1_src2(b[1]),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .alu_type(alu_type), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  alu_arbiter #(.DATA_W(DATA_W), .CNT_W(2)) dut_w (
    .clk(clk), .rst(rst),
    .req0_valid(v[0]), .req0_ready(w_req0_ready), .req0_type(t[0]), .req0_src1(a[0]), .req0_src2(b[0]),
    .req1_valid(v[1]), .req1_ready(w_req1_ready), .req1_type(t[1]), .req1_src1(a[1]), .req1_src2(b[1]),
    .rsp0_valid(w_rsp0_valid), .rsp0_ready(rr[0]), .rsp0_data(w_rsp0_data), .rsp0_err(w_rsp0_err),
    .rsp1_valid(w_rsp1_valid), .rsp1_ready(rr[1]), .rsp1_data(w_rsp1_data), .rsp1_err(w_rsp1_err),
    .alu_type(w_alu_type), .alu_src1(w_alu_src1), .alu_src2(w_alu_src2), .alu_result(w_alu_result),
    .gnt_cnt0(w_gnt_cnt0), .gnt_cnt1(w_gnt_cnt1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    m_last = 1;
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 1'b0;
      m_dat[i] = 32'd0;
      m_err[i] = 1'b0;
      m_cnt[i] = 0;
    end
  endtask

  // Compare every registered output of both instances with the model.
  task automatic checkState();
    checkOutput("rsp0_valid", 32'(rsp0_valid), 32'(m_val[0]));
    checkOutput("rsp1_valid", 32'(rsp1_valid), 32'(m_val[1]));
    checkOutput("rsp0_data", rsp0_data, m_dat[0]);
    checkOutput("rsp1_data", rsp1_data, m_dat[1]);
    checkOutput("rsp0_err", 32'(rsp0_err), 32'(m_err[0]));
    checkOutput("rsp1_err", 32'(rsp1_err), 32'(m_err[1]));
    checkOutput("gnt_cnt0", 32'(gnt_cnt0), 32'(m_cnt[0] % 65536));
    checkOutput("gnt_cnt1", 32'(gnt_cnt1), 32'(m_cnt[1] % 65536));
    checkOutput("w_rsp0_valid", 32'(w_rsp0_valid), 32'(m_val[0]));
    checkOutput("w_rsp1_valid", 32'(w_rsp1_valid), 32'(m_val[1]));
    checkOutput("w_rsp0_data", w_rsp0_data, m_dat[0]);
    checkOutput("w_rsp1_data", w_rsp1_data, m_dat[1]);
    checkOutput("w_rsp0_err", 32'(w_rsp0_err), 32'(m_err[0]));
    checkOutput("w_rsp1_err", 32'(w_rsp1_err), 32'(m_err[1]));
    checkOutput("w_gnt_cnt0", 32'(w_gnt_cnt0), 32'(m_cnt[0] % 4));
    checkOutput("w_gnt_cnt1", 32'(w_gnt_cnt1), 32'(m_cnt[1] % 4));
  endtask

  // One clock cycle: drive inputs at the falling edge, check the handshake and
  // ALU drive mid-cycle, advance the model at the rising edge, check state after.
  task automatic applyStimulus(input bit v0, input logic [3:0] t0, input logic [31:0] a0, input logic [31:0] b0,
                               input bit v1, input logic [3:0] t1, input logic [31:0] a1, input logic [31:0] b1,
                               input bit r0, input bit r1);
    int g;
    bit elig[2];
    v[0] = v0; t[0] = t0; a[0] = a0; b[0] = b0;
    v[1] = v1; t[1] = t1; a[1] = a1; b[1] = b1;
    rr[0] = r0; rr[1] = r1;
    #2;
    for (int i = 0; i < 2; i++) elig[i] = v[i] && (!m_val[i] || rr[i]);
    if (elig[0] && elig[1]) g = 1 - m_last;
    else if (elig[0])       g = 0;
    else if (elig[1])       g = 1;
    else                    g = -1;
    obs_r0 = req0_ready;
    obs_r1 = req1_ready;
    obs_type = alu_type;
    checkOutput("req0_ready", 32'(req0_ready), 32'(g == 0));
    checkOutput("req1_ready", 32'(req1_ready), 32'(g == 1));
    checkOutput("w_req0_ready", 32'(w_req0_ready), 32'(g == 0));
    checkOutput("w_req1_ready", 32'(w_req1_ready), 32'(g == 1));
    checkOutput("alu_type", 32'(alu_type), (g >= 0) ? 32'(t[g]) : 32'd8);
    checkOutput("alu_src1", alu_src1, (g >= 0) ? a[g] : 32'd0);
    checkOutput("alu_src2", alu_src2, (g >= 0) ? b[g] : 32'd0);
    checkOutput("w_alu_type", 32'(w_alu_type), (g >= 0) ? 32'(t[g]) : 32'd8);
    checkOutput("w_alu_src1", w_alu_src1, (g >= 0) ? a[g] : 32'd0);
    checkOutput("w_alu_src2", w_alu_src2, (g >= 0) ? b[g] : 32'd0);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (g == i) begin
        m_val[i] = 1'b1;
        m_dat[i] = alu_fn(t[i], a[i], b[i]);
        m_err[i] = (t[i] >= 4'd8);
        m_cnt[i] = m_cnt[i] + 1;
      end else if (m_val[i] && rr[i]) begin
        m_val[i] = 1'b0;
      end
    end
    if (g >= 0) m_last = g;
    last_g = g;
    #1;
    checkState();
    @(negedge clk);
  endtask

  // Assert reset mid-cycle and confirm it takes effect without a clock edge.
  task automatic doReset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    checkOutput("rst_gnt_cnt0", 32'(gnt_cnt0), 32'd0);
    checkOutput("rst_gnt_cnt1", 32'(gnt_cnt1), 32'd0);
    checkOutput("rst_req0_ready", 32'(req0_ready), 32'd0);
    checkOutput("rst_req1_ready", 32'(req1_ready), 32'd0);
    checkOutput("rst_alu_type", 32'(alu_type), 32'd8);
    checkOutput("rst_w_gnt_cnt0", 32'(w_gnt_cnt0), 32'd0);
    resetModel();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int seq[5];
    seq = '{1, 2, 3, 0, 1};
    resetModel();
    last_g = -1;
    v[0] = 1'b1; v[1] = 1'b1; rr[0] = 1'b1; rr[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin t[i] = 4'd0; a[i] = 32'd0; b[i] = 32'd0; end

    $display("[TB] reset and alternation");
    doReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 4'd0, 32'(k), 32'd1, 1'b1, 4'd1, 32'(k), 32'd1, 1'b1, 1'b1);
      checkOutput("alt_r0", 32'(obs_r0), 32'(k % 2 == 0));
      checkOutput("alt_r1", 32'(obs_r1), 32'(k % 2 == 1));
    end
    checkOutput("alt_cnt0", 32'(gnt_cnt0), 32'd4);
    checkOutput("alt_cnt1", 32'(gnt_cnt1), 32'd4);

    $display("[TB] single port 0 op");
    doReset();
    applyStimulus(1'b1, 4'd0, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("p0_ready", 32'(obs_r0), 32'd1);
    checkOutput("p0_valid", 32'(rsp0_valid), 32'd1);
    checkOutput("p0_data", rsp0_data, 32'd12);
    checkOutput("p0_cnt", 32'(gnt_cnt0), 32'd1);

    $display("[TB] backpressure on port 0");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 4'd0, 32'd100, 32'd23, 1'b1, 4'd6, 32'(k), 32'h10, 1'b0, 1'b1);
      checkOutput("bp_r0", 32'(obs_r0), 32'd0);
      checkOutput("bp_r1", 32'(obs_r1), 32'd1);
    end
    applyStimulus(1'b1, 4'd0, 32'd100, 32'd23, 1'b1, 4'd6, 32'd3, 32'h10, 1'b1, 1'b1);
    checkOutput("bp_pop_load_r0", 32'(obs_r0), 32'd1);
    checkOutput("bp_pop_load_valid", 32'(rsp0_valid), 32'd1);
    checkOutput("bp_pop_load_data", rsp0_data, 32'd123);

    $display("[TB] undefined op code");
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd9, 32'd6, 32'd3, 1'b1, 1'b1);
    checkOutput("ndef_alu_type", 32'(obs_type), 32'd9);
    checkOutput("ndef_err", 32'(rsp1_err), 32'd1);
    checkOutput("ndef_data", rsp1_data, 32'h0006_0003);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd4, 32'd6, 32'd3, 1'b1, 1'b1);
    checkOutput("xor_err", 32'(rsp1_err), 32'd0);
    checkOutput("xor_data", rsp1_data, 32'd5);

    $display("[TB] reset mid-operation");
    doReset();
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b1, 4'd7, 32'hFF, 32'(k), 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    checkOutput("pre_rst_valid", 32'(rsp0_valid), 32'd1);
    checkOutput("pre_rst_cnt0", 32'(gnt_cnt0), 32'd3);
    doReset();
    applyStimulus(1'b1, 4'd1, 32'd9, 32'd4, 1'b1, 4'd0, 32'd1, 32'd1, 1'b1, 1'b1);
    checkOutput("post_rst_winner", 32'(obs_r0), 32'd1);

    $display("[TB] narrow counter wrap");
    doReset();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 4'd2, 32'd1, 32'(k), 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
      checkOutput("wrap_cnt0", 32'(w_gnt_cnt0), 32'(seq[k]));
    end

    $display("[TB] randomized traffic");
    doReset();
    last_g = -1;
    v[0] = 1'b0; v[1] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(v[i] && last_g != i)) begin
          v[i] = ($urandom_range(0, 3) != 0);
          t[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
          a[i] = $urandom;
          b[i] = $urandom;
        end
        rr[i] = ($urandom_range(0, 9) < 7);
      end
      applyStimulus(v[0], t[0], a[0], b[0], v[1], t[1], a[1], b[1], rr[0], rr[1]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
